mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Three-requester round-robin arbiter in front of the data/program memory
//   maps. A request is granted from IDLE, the granted requester's address and
//   strobes are forwarded (registered) during ACCESS, and a one-cycle RELEASE
//   separates consecutive accesses. All outputs come straight from flops.
//
// Parameters
//   N        address width in bits
//   TIMEOUT  ACCESS cycles without bus_ack before a forced release (1..255)
//
// Ports
//   clk          clock, rising edge
//   nRESET       asynchronous active-low reset
//   req[2:0]     per-requester request, held by the requester until granted
//   req_address  requester i address in [i*N +: N]
//   req_read     per-requester read strobe
//   req_write    per-requester write strobe (wins over read)
//   bus_ack      completion from the memory maps
//   gnt[2:0]     one-hot grant, zero when idle
//   ack[2:0]     one-cycle completion pulse to the granted requester
//   bus_address  address to the memory maps (held through RELEASE/IDLE)
//   bus_read     read strobe to the memory maps
//   bus_write    write strobe to the memory maps
//   timeout_err  one-cycle pulse on a forced release
//
// Build option
//   MEM_BUS_ARBITER_TIMEOUT_EN  builds the 8-bit ACCESS wait counter and the
//   forced-release path; without it ACCESS waits for bus_ack indefinitely and
//   timeout_err is constant 0.
module mem_bus_arbiter #(
  parameter int N       = 32,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           nRESET,
  input  logic [2:0]     req,
  input  logic [3*N-1:0] req_address,
  input  logic [2:0]     req_read,
  input  logic [2:0]     req_write,
  input  logic           bus_ack,
  output logic [2:0]     gnt,
  output logic [2:0]     ack,
  output logic [N-1:0]   bus_address,
  output logic           bus_read,
  output logic           bus_write,
  output logic           timeout_err
);

  if ((TIMEOUT < 32'sd1) || (TIMEOUT > 32'sd255)) begin : g_timeout_range
    $error("mem_bus_arbiter: TIMEOUT must be within 1..255");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e       state_r, state_nxt_s;
  logic [1:0]   idx_r, idx_nxt_s;
  logic [1:0]   last_r, last_nxt_s;
  logic [2:0]   gnt_r, gnt_nxt_s;
  logic [2:0]   ack_r, ack_nxt_s;
  logic [N-1:0] addr_r, addr_nxt_s;
  logic         rd_r, rd_nxt_s;
  logic         wr_r, wr_nxt_s;
  logic         issued_r, issued_nxt_s;
  logic [1:0]   pick_s;
  logic [N-1:0] sel_addr_s;
  logic         sel_req_s, sel_rd_s, sel_wr_s;
  logic         tmo_fire_s;

  // Round-robin search starting just after the last completed requester.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] c0, c1, c2, pick;
    c0 = (last == 2'd2) ? 2'd0 : (last + 2'd1);
    c1 = (c0 == 2'd2) ? 2'd0 : (c0 + 2'd1);
    c2 = (c1 == 2'd2) ? 2'd0 : (c1 + 2'd1);
    if (r[c0]) begin
      pick = c0;
    end else if (r[c1]) begin
      pick = c1;
    end else if (r[c2]) begin
      pick = c2;
    end else begin
      pick = c0;
    end
    return pick;
  endfunction

  assign pick_s = rr_pick(req, last_r);

  // Select the granted requester's request, address and strobes.
  always_comb begin
    sel_req_s  = 1'b0;
    sel_rd_s   = 1'b0;
    sel_wr_s   = 1'b0;
    sel_addr_s = req_address[0 +: N];
    case (idx_r)
      2'd0: begin
        sel_req_s  = req[0];
        sel_rd_s   = req_read[0] & ~req_write[0];
        sel_wr_s   = req_write[0];
        sel_addr_s = req_address[0 +: N];
      end
      2'd1: begin
        sel_req_s  = req[1];
        sel_rd_s   = req_read[1] & ~req_write[1];
        sel_wr_s   = req_write[1];
        sel_addr_s = req_address[N +: N];
      end
      2'd2: begin
        sel_req_s  = req[2];
        sel_rd_s   = req_read[2] & ~req_write[2];
        sel_wr_s   = req_write[2];
        sel_addr_s = req_address[2*N +: N];
      end
      default: begin
        sel_req_s  = 1'b0;
        sel_rd_s   = 1'b0;
        sel_wr_s   = 1'b0;
        sel_addr_s = req_address[0 +: N];
      end
    endcase
  end

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt_r;
  logic       timeout_err_r;

  // Fires on the TIMEOUT-th ACCESS cycle; completion and abort take priority in the FSM.
  assign tmo_fire_s = (state_r == ACCESS) && (wait_cnt_r == TMO_LAST);

  // ACCESS wait counter: zeroed while idle so every access starts from 0.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      wait_cnt_r <= 8'd0;
    end else if (state_r == IDLE) begin
      wait_cnt_r <= 8'd0;
    end else if (state_r == ACCESS) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Timeout pulse only when the FSM really takes the forced-release branch.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= tmo_fire_s & ~(bus_ack & issued_r) & sel_req_s;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign tmo_fire_s  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state and next-output logic. bus_ack is honoured only once the
  // access has been presented on the bus (issued_r), which also fixes the
  // minimum turnaround at grant, access, ack, release.
  always_comb begin
    state_nxt_s  = state_r;
    idx_nxt_s    = idx_r;
    last_nxt_s   = last_r;
    gnt_nxt_s    = gnt_r;
    ack_nxt_s    = 3'b000;
    addr_nxt_s   = addr_r;
    rd_nxt_s     = 1'b0;
    wr_nxt_s     = 1'b0;
    issued_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_nxt_s = ACCESS;
          idx_nxt_s   = pick_s;
          gnt_nxt_s   = 3'b001 << pick_s;
        end else begin
          gnt_nxt_s   = 3'b000;
        end
      end
      ACCESS: begin
        if (bus_ack && issued_r) begin
          // completion wins over a simultaneous request drop
          state_nxt_s = RELEASE;
          ack_nxt_s   = gnt_r;
          last_nxt_s  = idx_r;
          gnt_nxt_s   = 3'b000;
        end else if (!sel_req_s) begin
          state_nxt_s = RELEASE;
          gnt_nxt_s   = 3'b000;
        end else if (tmo_fire_s) begin
          state_nxt_s = RELEASE;
          last_nxt_s  = idx_r;
          gnt_nxt_s   = 3'b000;
        end else begin
          addr_nxt_s   = sel_addr_s;
          rd_nxt_s     = sel_rd_s;
          wr_nxt_s     = sel_wr_s;
          issued_nxt_s = 1'b1;
        end
      end
      RELEASE: begin
        state_nxt_s = IDLE;
        gnt_nxt_s   = 3'b000;
      end
      default: begin
        state_nxt_s = IDLE;
        gnt_nxt_s   = 3'b000;
      end
    endcase
  end

  // State and output registers; reset clears strobes without waiting for clk.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_r  <= IDLE;
      idx_r    <= 2'd0;
      last_r   <= 2'd2;
      gnt_r    <= 3'b000;
      ack_r    <= 3'b000;
      addr_r   <= '0;
      rd_r     <= 1'b0;
      wr_r     <= 1'b0;
      issued_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      idx_r    <= idx_nxt_s;
      last_r   <= last_nxt_s;
      gnt_r    <= gnt_nxt_s;
      ack_r    <= ack_nxt_s;
      addr_r   <= addr_nxt_s;
      rd_r     <= rd_nxt_s;
      wr_r     <= wr_nxt_s;
      issued_r <= issued_nxt_s;
    end
  end

  assign gnt         = gnt_r;
  assign ack         = ack_r;
  assign bus_address = addr_r;
  assign bus_read    = rd_r;
  assign bus_write   = wr_r;

endmodule
